// File: rtl/ddr_queue_drain_scheduler.sv
// Slot-driven round-robin read scheduler for P_QUEUE_NUM local DDR queues.
// Each slot gets a byte budget. Each eligible queue receives its whole backlog
// as one read grant. The scheduler then waits for that queue's finish flag.
module ddr_queue_drain_scheduler #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int P_QUEUE_NUM        = 4,
  parameter int P_MIN_PKT_BYTE     = 64,
  parameter int P_WAIT_TIMEOUT     = 65535
) (
  input  logic                                      i_clk,
  input  logic                                      i_rst,
  input  logic                                      i_slot_valid,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]             i_slot_budget,
  output logic                                      o_slot_ready,
  input  logic [P_QUEUE_NUM*C_M_AXI_ADDR_WIDTH-1:0] i_queue_size,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]             o_rd_local_byte,
  output logic [P_QUEUE_NUM-1:0]                    o_rd_local_byte_valid,
  input  logic [P_QUEUE_NUM-1:0]                    i_rd_local_byte_ready,
  input  logic [P_QUEUE_NUM-1:0]                    i_rd_queue_finish,
  output logic [7:0]                                o_active_queue,
  output logic                                      o_slot_done,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]             o_slot_used_byte,
  output logic                                      o_timeout_err
);
  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int QW = $clog2(P_QUEUE_NUM);
  localparam int TW = $clog2(P_WAIT_TIMEOUT + 1);
  localparam logic [AW-1:0] MIN_B   = AW'(P_MIN_PKT_BYTE);
  localparam logic [QW-1:0] LAST_Q  = QW'(P_QUEUE_NUM - 1);
  localparam logic [TW-1:0] TMO_END = TW'(P_WAIT_TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_SELECT, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t                 r_state, w_next;
  logic [QW-1:0]          r_ptr, r_scan;
  logic [AW-1:0]          r_rem, r_used, r_grant;
  logic [TW-1:0]          r_timer;
  logic [1:0]             r_guard;

  logic                   r_slot_ready, r_slot_done, r_timeout_err;
  logic [AW-1:0]          r_rd_byte, r_used_out;
  logic [P_QUEUE_NUM-1:0] r_rd_valid;

  logic [AW-1:0]          w_size;
  logic                   w_hit, w_rdy, w_fin, w_guard_ok, w_tmo, w_wait_end, w_accept;
  logic [QW-1:0]          w_ptr_inc;
  logic [P_QUEUE_NUM-1:0] w_onehot;

  // Backlog of the queue currently under the pointer
  always_comb begin
    w_size = '0;
    for (int k = 0; k < P_QUEUE_NUM; k++)
      if (r_ptr == QW'(k)) w_size = i_queue_size[k*AW +: AW];
  end

  assign w_hit      = (w_size >= MIN_B) && (w_size <= r_rem);
  assign w_rdy      = i_rd_local_byte_ready[r_ptr];
  assign w_fin      = i_rd_queue_finish[r_ptr];
  // The finish flag is stale for two cycles after the handshake.
  assign w_guard_ok = (r_guard == 2'd2);
  assign w_tmo      = (r_timer == TMO_END);
  assign w_wait_end = (w_guard_ok && w_fin) || w_tmo;
  assign w_accept   = i_slot_valid && r_slot_ready;
  assign w_ptr_inc  = (r_ptr == LAST_Q) ? '0 : r_ptr + 1'b1;
  assign w_onehot   = {{(P_QUEUE_NUM-1){1'b0}}, 1'b1} << r_ptr;

  // FSM state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // FSM next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_next = S_SELECT;
      S_SELECT: if (w_hit) w_next = S_ISSUE;
                else if (r_scan == LAST_Q) w_next = S_DONE;
      S_ISSUE:  if (w_rdy) w_next = S_WAIT;
      S_WAIT:   if (w_wait_end) w_next = S_SELECT;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Scheduler datapath: pointer, scan count, budget and wait bookkeeping
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ptr         <= '0;
      r_scan        <= '0;
      r_rem         <= '0;
      r_used        <= '0;
      r_grant       <= '0;
      r_timer       <= '0;
      r_guard       <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_rem  <= i_slot_budget;
          r_used <= '0;
          r_scan <= '0;
        end
        S_SELECT: begin
          if (w_hit) r_grant <= w_size;
          else begin
            r_ptr  <= w_ptr_inc;
            r_scan <= r_scan + 1'b1;
          end
        end
        S_ISSUE: if (w_rdy) begin
          r_guard <= '0;
          r_timer <= '0;
        end
        S_WAIT: begin
          if (w_wait_end) begin
            // A timed-out grant is still charged to the slot.
            r_used <= r_used + r_grant;
            r_rem  <= r_rem - r_grant;
            r_ptr  <= w_ptr_inc;
            r_scan <= '0;
            if (!(w_guard_ok && w_fin)) r_timeout_err <= 1'b1;
          end else begin
            if (!w_guard_ok) r_guard <= r_guard + 2'd1;
            r_timer <= r_timer + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Registered outputs, decoded from the state being entered
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_slot_ready <= 1'b0;
      r_slot_done  <= 1'b0;
      r_used_out   <= '0;
      r_rd_valid   <= '0;
      r_rd_byte    <= '0;
    end else begin
      r_slot_ready <= (w_next == S_IDLE);
      r_slot_done  <= (w_next == S_DONE);
      r_used_out   <= (w_next == S_DONE) ? r_used : '0;
      r_rd_valid   <= (w_next == S_ISSUE) ? w_onehot : '0;
      if (w_next == S_ISSUE) r_rd_byte <= (r_state == S_SELECT) ? w_size : r_grant;
      else                   r_rd_byte <= '0;
    end
  end

  assign o_slot_ready          = r_slot_ready;
  assign o_slot_done           = r_slot_done;
  assign o_slot_used_byte      = r_used_out;
  assign o_rd_local_byte_valid = r_rd_valid;
  assign o_rd_local_byte       = r_rd_byte;
  assign o_timeout_err         = r_timeout_err;
  assign o_active_queue        = 8'(r_ptr);
endmodule

// File: tb/tb_ddr_queue_drain_scheduler.sv
// Directed bench for ddr_queue_drain_scheduler: slot table plus corner sequences.
module tb_ddr_queue_drain_scheduler;
  localparam int AW = 32;
  localparam int N  = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            slot_valid;
  logic [AW-1:0]   slot_budget;
  logic            slot_ready;
  logic [N*AW-1:0] qsize;
  logic [AW-1:0]   rd_byte;
  logic [N-1:0]    rd_valid, rd_ready, fin;
  logic [7:0]      active;
  logic            slot_done;
  logic [AW-1:0]   used_byte;
  logic            terr;

  always #5 clk = ~clk;

  ddr_queue_drain_scheduler #(
    .C_M_AXI_ADDR_WIDTH(AW), .P_QUEUE_NUM(N), .P_MIN_PKT_BYTE(64), .P_WAIT_TIMEOUT(100)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_slot_valid(slot_valid), .i_slot_budget(slot_budget),
    .o_slot_ready(slot_ready), .i_queue_size(qsize), .o_rd_local_byte(rd_byte),
    .o_rd_local_byte_valid(rd_valid), .i_rd_local_byte_ready(rd_ready),
    .i_rd_queue_finish(fin), .o_active_queue(active), .o_slot_done(slot_done),
    .o_slot_used_byte(used_byte), .o_timeout_err(terr)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Queue model: accepts each request after rdy_delay cycles, then finishes
  // 4 cycles after the handshake and drains the queue.
  logic          auto_resp = 1'b0;
  int            rdy_delay = 0;
  int            g_cnt = 0;
  int            g_q[8];
  logic [AW-1:0] g_b[8];

  task automatic responder();
    int k;
    forever begin
      @(negedge clk);
      if (auto_resp && rd_valid != '0) begin
        k = 0;
        for (int i = 0; i < N; i++) if (rd_valid[i]) k = i;
        if (g_cnt < 8) begin g_q[g_cnt] = k; g_b[g_cnt] = rd_byte; end
        g_cnt++;
        repeat (rdy_delay) @(negedge clk);
        rd_ready[k] = 1'b1;
        @(negedge clk);
        rd_ready[k] = 1'b0;
        repeat (3) @(negedge clk);
        qsize[k*AW +: AW] = '0;
        fin[k] = 1'b1;
        @(negedge clk);
        fin[k] = 1'b0;
      end
    end
  endtask

  int onehot_bad = 0;
  always @(negedge clk)
    if ((rd_valid & (rd_valid - 1'b1)) != '0) onehot_bad++;

  task automatic start_slot(input logic [AW-1:0] b);
    int n;
    n = 0;
    while (!slot_ready && n < 100) begin @(negedge clk); n++; end
    chk("slot_ready_wait", slot_ready, 1);
    slot_budget = b;
    slot_valid  = 1'b1;
    @(negedge clk);
    slot_valid  = 1'b0;
  endtask

  task automatic wait_done(output logic [AW-1:0] u, output logic [7:0] aq);
    int n;
    n = 0;
    while (!slot_done && n < 3000) begin @(negedge clk); n++; end
    chk("slot_done_wait", slot_done, 1);
    u  = used_byte;
    aq = active;
    @(negedge clk);
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (rd_valid == '0 && n < 100) begin @(negedge clk); n++; end
    chk("valid_wait", (rd_valid != '0), 1);
  endtask

  typedef struct {
    logic [AW-1:0] sz[N];
    logic [AW-1:0] budget;
    int            rdly;
    logic [AW-1:0] used;
    int            ng;
    int            q0;
    logic [AW-1:0] b0;
    int            q1;
    logic [AW-1:0] b1;
    int            ptr;
  } vec_t;

  vec_t tv[6];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [AW-1:0] u;
    logic [7:0]    aq;
    int            first, stall_bad, anyv;

    // sizes, budget, ready delay, used, #grants, q/byte 0, q/byte 1, next ptr
    tv[0] = '{sz:'{1500,1500,1500,1500}, budget:4000, rdly:0, used:3000, ng:2, q0:0, b0:1500, q1:1, b1:1500, ptr:2};
    tv[1] = '{sz:'{0,3000,0,0},          budget:10000, rdly:2, used:3000, ng:1, q0:1, b0:3000, q1:0, b1:0, ptr:2};
    tv[2] = '{sz:'{0,0,0,0},             budget:5000, rdly:0, used:0, ng:0, q0:0, b0:0, q1:0, b1:0, ptr:2};
    tv[3] = '{sz:'{100,63,64,5000},      budget:200, rdly:1, used:164, ng:2, q0:2, b0:64, q1:0, b1:100, ptr:1};
    tv[4] = '{sz:'{64,64,64,64},         budget:0, rdly:0, used:0, ng:0, q0:0, b0:0, q1:0, b1:0, ptr:1};
    tv[5] = '{sz:'{0,700,0,0},           budget:700, rdly:3, used:700, ng:1, q0:1, b0:700, q1:0, b1:0, ptr:2};

    rst = 1'b1; slot_valid = 1'b0; slot_budget = '0; qsize = '0; rd_ready = '0; fin = '0;
    fork responder(); join_none
    repeat (3) @(negedge clk);

    chk("rst_ready", slot_ready, 0);
    chk("rst_valid", rd_valid, 0);
    chk("rst_byte", rd_byte, 0);
    chk("rst_done", slot_done, 0);
    chk("rst_used", used_byte, 0);
    chk("rst_active", active, 0);
    chk("rst_terr", terr, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", slot_ready, 1);

    // Table-driven slots with the automatic queue model
    auto_resp = 1'b1;
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < N; k++) qsize[k*AW +: AW] = tv[i].sz[k];
      rdy_delay = tv[i].rdly;
      g_cnt = 0;
      start_slot(tv[i].budget);
      wait_done(u, aq);
      chk($sformatf("v%0d_used", i), u, tv[i].used);
      chk($sformatf("v%0d_ngrant", i), g_cnt, tv[i].ng);
      if (tv[i].ng >= 1) begin
        chk($sformatf("v%0d_q0", i), g_q[0], tv[i].q0);
        chk($sformatf("v%0d_b0", i), g_b[0], tv[i].b0);
      end
      if (tv[i].ng >= 2) begin
        chk($sformatf("v%0d_q1", i), g_q[1], tv[i].q1);
        chk($sformatf("v%0d_b1", i), g_b[1], tv[i].b1);
      end
      chk($sformatf("v%0d_ptr", i), aq, tv[i].ptr);
    end
    auto_resp = 1'b0;

    // Empty slot timing: done in T+N+1, ready back in T+N+2
    qsize = '0;
    while (!slot_ready) @(negedge clk);
    slot_budget = 5000; slot_valid = 1'b1;
    first = 0; anyv = 0;
    for (int s = 1; s <= 8; s++) begin
      @(negedge clk);
      if (s == 1) begin slot_valid = 1'b0; chk("empty_ready_low", slot_ready, 0); end
      if (slot_done && first == 0) begin first = s; chk("empty_used", used_byte, 0); end
      if (rd_valid != '0) anyv = 1;
      if (s == N + 2) chk("empty_ready_back", slot_ready, 1);
    end
    chk("empty_done_cycle", first, N + 1);
    chk("empty_no_valid", anyv, 0);

    // Handshake stall and finish guard on q2 (pointer is at 2)
    qsize[2*AW +: AW] = 800;
    start_slot(1000);
    wait_valid();
    chk("stall_valid", rd_valid, 4'b0100);
    chk("stall_byte", rd_byte, 800);
    fin[2] = 1'b1;
    stall_bad = 0;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      if (rd_valid !== 4'b0100 || rd_byte !== 800) stall_bad++;
    end
    chk("stall_stable", stall_bad, 0);
    rd_ready[2] = 1'b1;
    @(negedge clk);
    rd_ready[2] = 1'b0;
    chk("hs_valid_drop", rd_valid, 0);
    chk("guard_r1", active, 2);
    @(negedge clk);
    chk("guard_r2", active, 2);
    @(negedge clk);
    chk("guard_r3", active, 2);
    @(negedge clk);
    chk("finish_r4", active, 3);
    fin[2] = 1'b0;
    qsize[2*AW +: AW] = '0;
    wait_done(u, aq);
    chk("stall_used", u, 800);

    // Timeout on q3, then scheduling continues with q0
    qsize[3*AW +: AW] = 500;
    qsize[0*AW +: AW] = 300;
    g_cnt = 0; rdy_delay = 0;
    start_slot(1000);
    wait_valid();
    chk("tmo_valid", rd_valid, 4'b1000);
    chk("tmo_err_pre", terr, 0);
    rd_ready[3] = 1'b1;
    qsize[3*AW +: AW] = '0;
    first = 0;
    for (int s = 1; s <= 110; s++) begin
      @(negedge clk);
      if (s == 1) begin rd_ready[3] = 1'b0; auto_resp = 1'b1; end
      if (terr && first == 0) first = s;
      if (slot_done) break;
    end
    chk("tmo_cycle", first, 101);
    wait_done(u, aq);
    chk("tmo_used", u, 800);
    chk("tmo_next_q", g_q[0], 0);
    chk("tmo_next_b", g_b[0], 300);
    repeat (3) @(negedge clk);
    chk("tmo_sticky", terr, 1);
    auto_resp = 1'b0;

    // Reset while a request is pending
    qsize = '0;
    qsize[1*AW +: AW] = 200;
    start_slot(1000);
    wait_valid();
    chk("rst_mid_valid", rd_valid, 4'b0010);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_valid0", rd_valid, 0);
    chk("rst_mid_byte0", rd_byte, 0);
    chk("rst_mid_ready0", slot_ready, 0);
    chk("rst_mid_active0", active, 0);
    chk("rst_mid_terr0", terr, 0);
    chk("rst_mid_done0", slot_done, 0);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_rel_ready0", slot_ready, 0);
    @(negedge clk);
    chk("rst_rel_ready1", slot_ready, 1);
    chk("rst_rel_ptr", active, 0);

    // First slot after reset starts scanning at q0
    qsize = '0;
    qsize[0*AW +: AW] = 64;
    g_cnt = 0; auto_resp = 1'b1;
    start_slot(64);
    wait_done(u, aq);
    chk("post_rst_used", u, 64);
    chk("post_rst_q", g_q[0], 0);
    auto_resp = 1'b0;

    chk("onehot_valid", onehot_bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
